// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 16 lines of 256 bits.
// Hits complete combinationally in IDLE; misses stall the pipeline while the line is refilled.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_we_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_wdata_i,
    output logic [31:0]  cpu_rdata_o,
    output logic         cpu_stall_o,
    output logic         mem_req_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_wdata_o,
    input  logic         mem_ack_i,
    input  logic [255:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t       state_q, state_d;
    logic         valid_q [16];
    logic         dirty_q [16];
    logic [22:0]  tag_q   [16];
    logic [255:0] data_q  [16];
    logic [26:0]  line_addr_q;

    logic [22:0]  req_tag;
    logic [3:0]   req_idx;
    logic [2:0]   req_word;
    logic [22:0]  lat_tag;
    logic [3:0]   lat_idx;
    logic         hit;
    logic         store_hit;
    logic         latch_miss;
    logic         fill_done;
    logic         unused_addr_bits;

    assign req_tag          = cpu_addr_i[31:9];
    assign req_idx          = cpu_addr_i[8:5];
    assign req_word         = cpu_addr_i[4:2];
    assign lat_tag          = line_addr_q[26:4];
    assign lat_idx          = line_addr_q[3:0];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Reset masks the CPU side so nothing is reported or latched while rst_i is high.
    assign hit       = !rst_i && cpu_req_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign store_hit = (state_q == IDLE) && hit && cpu_we_i;

    always_comb begin
        state_d     = state_q;
        cpu_rdata_o = '0;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        latch_miss  = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i && !rst_i) begin
                    if (hit) begin
                        cpu_rdata_o = data_q[req_idx][{req_word, 5'b0} +: 32];
                    end else begin
                        cpu_stall_o = 1'b1;
                        latch_miss  = 1'b1;
                        state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[lat_idx], lat_idx, 5'b0};
                mem_wdata_o = data_q[lat_idx];
                if (mem_ack_i) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {lat_tag, lat_idx, 5'b0};
                if (mem_ack_i) begin
                    fill_done = !rst_i;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            for (int i = 0; i < 16; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (latch_miss) begin
                line_addr_q <= cpu_addr_i[31:5];
            end
            if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[lat_idx] <= 1'b1;
                dirty_q[lat_idx] <= 1'b0;
            end
        end
    end

    // Tag and data need no reset: a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            tag_q[lat_idx]  <= lat_tag;
            data_q[lat_idx] <= mem_rdata_i;
        end else if (store_hit) begin
            data_q[req_idx][{req_word, 5'b0} +: 32] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: directed vector table, hand-written reset/ack corner
// sequences, and random traffic checked against a line-level cache model.
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack;
    logic [255:0] mem_rdata;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cache contents per line plus a sparse backing memory.
    logic         mv [16];
    logic         md [16];
    logic [22:0]  mt [16];
    logic [255:0] mdat [16];
    logic [255:0] mem [logic [26:0]];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        int          exp_stalls;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [5];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %064h want %064h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_word(input logic [26:0] la, input int w);
        return 32'h9E37_79B9 * (32'(la) * 32'd8 + 32'(w) + 32'd1);
    endfunction

    function automatic logic [255:0] mem_line(input logic [26:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat_word(la, w);
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    task automatic chk_quiet_mem(input string tag);
        chk1({tag, "_memreq"}, mem_req_o, 1'b0);
        chk32({tag, "_memaddr"}, mem_addr_o, 32'h0);
        chk256({tag, "_memwdata"}, mem_wdata_o, 256'h0);
    endtask

    // One CPU access. Called and returns 1 time unit after a rising edge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, output logic [31:0] got_rd, output int stalls);
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic         hit;
        logic         wb;
        logic [255:0] fill;
        idx    = addr[8:5];
        tag    = addr[31:9];
        hit    = mv[idx] && (mt[idx] == tag);
        wb     = !hit && mv[idx] && md[idx];
        stalls = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (!hit) begin
            @(negedge clk);
            chk1("miss_stall", cpu_stall_o, 1'b1);
            chk_quiet_mem("miss");
            if (cpu_stall_o) stalls++;
            @(posedge clk); #1;
            if (wb) begin
                for (int c = 0; c <= lat; c++) begin
                    mem_ack   = (c == lat);
                    mem_rdata = rand_line();
                    @(negedge clk);
                    chk1("wb_stall", cpu_stall_o, 1'b1);
                    chk1("wb_req", mem_req_o, 1'b1);
                    chk1("wb_write", mem_write_o, 1'b1);
                    chk32("wb_addr", mem_addr_o, {mt[idx], idx, 5'b0});
                    chk256("wb_data", mem_wdata_o, mdat[idx]);
                    if (cpu_stall_o) stalls++;
                    @(posedge clk); #1;
                    mem_ack = 1'b0;
                end
                mem[{mt[idx], idx}] = mdat[idx];
            end
            fill = mem_line({tag, idx});
            for (int c = 0; c <= lat; c++) begin
                mem_ack   = (c == lat);
                mem_rdata = (c == lat) ? fill : rand_line();
                @(negedge clk);
                chk1("al_stall", cpu_stall_o, 1'b1);
                chk1("al_req", mem_req_o, 1'b1);
                chk1("al_write", mem_write_o, 1'b0);
                chk32("al_addr", mem_addr_o, {tag, idx, 5'b0});
                if (cpu_stall_o) stalls++;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
            mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = tag; mdat[idx] = fill;
        end
        @(negedge clk);
        chk1("hit_stall", cpu_stall_o, 1'b0);
        chk_quiet_mem("hit");
        if (!we) chk32("hit_rdata", cpu_rdata_o, mdat[idx][addr[4:2]*32 +: 32]);
        got_rd = cpu_rdata_o;
        if (cpu_stall_o) stalls++;
        if (we) begin
            mdat[idx][addr[4:2]*32 +: 32] = wd;
            md[idx] = 1'b1;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic idle_cycle(input logic ack);
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        mem_ack   = ack;
        mem_rdata = rand_line();
        @(negedge clk);
        chk1("idle_stall", cpu_stall_o, 1'b0);
        chk32("idle_rdata", cpu_rdata_o, 32'h0);
        chk_quiet_mem("idle");
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        int           st;
        logic [255:0] seed;

        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0104;
        cpu_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = '0;
        model_reset();

        // Reset with a request pending: everything must read as zero.
        @(posedge clk); #1;
        @(negedge clk);
        chk1("rst_stall", cpu_stall_o, 1'b0);
        chk32("rst_rdata", cpu_rdata_o, 32'h0);
        chk1("rst_write", mem_write_o, 1'b0);
        chk_quiet_mem("rst");
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;

        seed = mem_line(27'h8);
        seed[63:32] = 32'hDEAD_BEEF;
        mem[27'h8] = seed;

        tbl[0] = '{1'b0, 32'h0000_0104, 32'h0,          3, 5, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 0, 0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h0000_0104, 32'h0,          0, 0, 1'b1, 32'h1234_5678};
        tbl[3] = '{1'b0, 32'h0000_0304, 32'h0,          2, 7, 1'b1, pat_word(27'h18, 1)};
        tbl[4] = '{1'b0, 32'h0000_0304, 32'h0,          0, 0, 1'b1, pat_word(27'h18, 1)};
        for (int i = 0; i < 5; i++) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].lat, rd, st);
            chk32($sformatf("vec%0d_stalls", i), 32'(st), 32'(tbl[i].exp_stalls));
            if (tbl[i].chk_rd) chk32($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        chk256("wb_to_mem_0x100", mem_line(27'h8), {seed[255:64], 32'h1234_5678, seed[31:0]});

        // Reset in the second ALLOCATE cycle, colliding with the ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0504;
        @(negedge clk);
        chk1("r42_miss_stall", cpu_stall_o, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk32("r42_al1_addr", mem_addr_o, 32'h0000_0500);
        @(posedge clk); #1;
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = rand_line();
        @(negedge clk);
        chk1("r42_al2_req", mem_req_o, 1'b1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk1("r42_post_req", mem_req_o, 1'b0);
        chk1("r42_post_stall", cpu_stall_o, 1'b0);
        chk1("r42_post_write", mem_write_o, 1'b0);
        chk32("r42_post_rdata", cpu_rdata_o, 32'h0);
        chk_quiet_mem("r42_post");
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b0;
        model_reset();
        access(1'b0, 32'h0000_0304, 32'h0, 1, rd, st);
        chk32("r42_refetch_stalls", 32'(st), 32'd3);
        access(1'b0, 32'h0000_0504, 32'h0, 0, rd, st);
        chk32("r42_discarded_fill_stalls", 32'(st), 32'd2);

        // Stray ack in IDLE must not disturb anything.
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        access(1'b0, 32'h0000_0504, 32'h0, 0, rd, st);
        chk32("stray_ack_hit_stalls", 32'(st), 32'd0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(1'($urandom));
            end else begin
                access(1'($urandom),
                       {21'h0, 2'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'($urandom)},
                       $urandom, $urandom_range(0, 3), rd, st);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters: 16 lines, 256-bit lines, direct-mapped, write-back, write-allocate, all fixed.
REQ-002 clk_i  input  1  clock; all state SHALL update on the rising edge only.
REQ-003 rst_i  input  1  reset; SHALL be synchronous and active-high.
REQ-004 cpu_req_i  input  1  MEM-stage load/store request valid.
REQ-005 cpu_we_i  input  1  1=store, 0=load.
REQ-006 cpu_addr_i  input  32  byte address; tag=[31:9], index=[8:5], word=[4:2], [1:0] ignored.
REQ-007 cpu_wdata_i  input  32  store data.
REQ-008 cpu_rdata_o  output  32  load data, valid when cpu_req_i=1 and cpu_stall_o=0.
REQ-009 cpu_stall_o  output  1  freezes the whole pipeline while high.
REQ-010 mem_req_o  output  1  backing-memory request.
REQ-011 mem_write_o  output  1  1=line write-back, 0=line fetch.
REQ-012 mem_addr_o  output  32  line-aligned address, bits [4:0]=0.
REQ-013 mem_wdata_o  output  256  victim line data.
REQ-014 mem_ack_i  input  1  single-cycle completion pulse from memory.
REQ-015 mem_rdata_i  input  256  fetched line, valid in the mem_ack_i cycle.

Function
REQ-016 Per-line storage SHALL be valid bit, dirty bit, 23-bit tag and 256-bit data; word w SHALL occupy data bits [32w+31:32w].
REQ-017 Hit SHALL mean cpu_req_i=1, line valid, and stored tag equal to cpu_addr_i[31:9].
REQ-018 The FSM SHALL have states IDLE, WRITEBACK and ALLOCATE.
REQ-019 In IDLE, a hit SHALL give cpu_stall_o=0 combinationally and cpu_rdata_o=the addressed word in the same cycle (zero-latency).
REQ-020 A store hit SHALL write cpu_wdata_i into the addressed word and set dirty at the clock edge; the other 7 words SHALL be unchanged.
REQ-021 In IDLE, a miss SHALL drive cpu_stall_o=1 combinationally in the same cycle.
REQ-022 On a miss, the controller SHALL latch the request address and go to WRITEBACK if the victim is valid and dirty, else go to ALLOCATE.
REQ-023 In WRITEBACK the controller SHALL drive mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0} and mem_wdata_o=victim data.
REQ-024 WRITEBACK outputs SHALL be held stable until mem_ack_i, after which the FSM SHALL go to ALLOCATE.
REQ-025 In ALLOCATE the controller SHALL drive mem_req_o=1, mem_write_o=0 and mem_addr_o={latched tag, index, 5'b0}.
REQ-026 On mem_ack_i in ALLOCATE, the controller SHALL write mem_rdata_i into the line, set valid=1, dirty=0 and tag=latched tag, then return to IDLE.
REQ-027 On return to IDLE, the held request SHALL re-evaluate as a hit and complete per REQ-019/REQ-020, giving a clean miss of 2 stall cycles plus memory latency.
REQ-028 cpu_stall_o SHALL be 1 in every cycle spent in WRITEBACK or ALLOCATE.
REQ-029 mem_req_o SHALL be 0 in IDLE, and mem_ack_i SHALL be ignored in IDLE.
REQ-030 The CPU SHALL hold cpu_req_i, cpu_addr_i, cpu_we_i and cpu_wdata_i stable while cpu_stall_o=1; the controller SHALL use only the latched address for memory traffic.
REQ-031 A store miss SHALL be write-allocate: the line is fetched first, then the store hits in IDLE and sets dirty.
REQ-032 When cpu_req_i=0 in IDLE, cpu_stall_o SHALL be 0, no state SHALL change, and cpu_rdata_o SHALL be 0.
REQ-033 When mem_wdata_o and mem_addr_o are not in use (IDLE), they SHALL be driven 0.

Reset
REQ-034 While rst_i=1 at a clock edge, the FSM SHALL go to IDLE, all valid and dirty bits SHALL clear, and the latched address SHALL clear.
REQ-035 During reset, mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o, cpu_stall_o and cpu_rdata_o SHALL be 0 from the first cycle after the reset edge.
REQ-036 Reset during WRITEBACK or ALLOCATE SHALL abandon the transaction, with no line update and mem_req_o=0 in the next cycle.
REQ-037 If rst_i and mem_ack_i arrive in the same cycle, reset SHALL win and the fill SHALL be discarded.
REQ-038 Tag and data arrays need not be reset; valid=0 makes them don't-care.

Verification
REQ-039 Cold load 0x0000_0104, memory acks after 3 cycles with word1=0xDEAD_BEEF -> stall is high from request through ALLOCATE, then rdata=0xDEAD_BEEF with stall=0; no write-back issued.
REQ-040 Store 0x1234_5678 to 0x0000_0104 after REQ-039 -> zero stall; a following load of 0x0000_0104 returns 0x1234_5678; line 8 dirty=1.
REQ-041 Load 0x0000_0304 (same index 8, different tag) after REQ-040 -> WRITEBACK to mem_addr 0x0000_0100 with word1=0x1234_5678, then ALLOCATE at 0x0000_0300, then hit.
REQ-042 Assert rst_i in the second ALLOCATE cycle, then load 0x0000_0304 -> mem_req_o=0 the next cycle, the line is invalid, and a full miss repeats.
REQ-043 Pulse mem_ack_i while in IDLE with no request -> no state change, stall=0, mem_req_o=0.
